// File: rtl/instr_sequencer_if.sv
// Bus between the instruction sequencer, its program ROM and the CPU control unit.
// The master side is the sequencer; the slave side is the ROM/control-unit environment.
interface instr_sequencer_if #(
  parameter  int ADDR_W  = 8,
  localparam int INSTR_W = 4 + ADDR_W
) ();
  logic [ADDR_W-1:0]  instrAddr;
  logic               instrRd;
  logic [INSTR_W-1:0] instrData;
  logic [3:0]         opCode;
  logic [ADDR_W-1:0]  operand;
  logic               busy;
  logic               halted;

  modport master (
    output instrAddr, instrRd, opCode, operand, busy, halted,
    input  instrData
  );

  modport slave (
    input  instrAddr, instrRd, opCode, operand, busy, halted,
    output instrData
  );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction fetch/issue sequencer: reads a registered-read ROM, issues each opcode for
// ISSUE_CYCLES clocks, handles JMP/HALT locally. Define SEQ_SINGLE_STEP_EN for step-gated PAUSE.
module instr_sequencer #(
  parameter  int ADDR_W       = 8,
  parameter  int ISSUE_CYCLES = 2,
  localparam int INSTR_W      = 4 + ADDR_W
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic step,
`endif
  instr_sequencer_if.master bus
);
  localparam int CNT_W = (ISSUE_CYCLES > 1) ? $clog2(ISSUE_CYCLES) : 1;
  localparam logic [3:0]       OP_JMP   = 4'hE;
  localparam logic [3:0]       OP_HALT  = 4'hF;
  localparam logic [3:0]       OP_NOP   = 4'hF;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ISSUE_CYCLES - 1);

  typedef enum logic [2:0] {
    stIdle   = 3'd0,
    stFetch  = 3'd1,
    stWait   = 3'd2,
    stDecode = 3'd3,
    stIssue  = 3'd4,
    stHalted = 3'd5
`ifdef SEQ_SINGLE_STEP_EN
    , stPause = 3'd6
`endif
  } state_t;

  state_t             stateReg, stateNext;
  logic [ADDR_W-1:0]  pcReg, pcNext;
  logic [INSTR_W-1:0] irReg, irNext;
  logic [3:0]         opCodeReg, opCodeNext;
  logic [ADDR_W-1:0]  operandReg, operandNext;
  logic [CNT_W-1:0]   cntReg, cntNext;
  logic               rdReg, rdNext;
  logic               busyNow;

  logic [3:0]        irOp;
  logic [ADDR_W-1:0] irOperand;
  assign irOp      = irReg[INSTR_W-1 -: 4];
  assign irOperand = irReg[ADDR_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg   <= stIdle;
      pcReg      <= '0;
      irReg      <= '0;
      opCodeReg  <= OP_NOP;
      operandReg <= '0;
      cntReg     <= '0;
      rdReg      <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      pcReg      <= pcNext;
      irReg      <= irNext;
      opCodeReg  <= opCodeNext;
      operandReg <= operandNext;
      cntReg     <= cntNext;
      rdReg      <= rdNext;
    end
  end

  // The read strobe is registered: it is raised on every transition into FETCH.
  always_comb begin
    stateNext   = stateReg;
    pcNext      = pcReg;
    irNext      = irReg;
    opCodeNext  = opCodeReg;
    operandNext = operandReg;
    cntNext     = cntReg;
    rdNext      = 1'b0;
    case (stateReg)
      stIdle, stHalted: begin
        if (start) begin
          pcNext    = '0;
          stateNext = stFetch;
          rdNext    = 1'b1;
        end
      end
      stFetch: stateNext = stWait;
      stWait: begin
        irNext    = bus.instrData;
        stateNext = stDecode;
      end
      stDecode: begin
        if (irOp == OP_HALT) begin
          stateNext = stHalted;
        end else if (irOp == OP_JMP) begin
          pcNext    = irOperand;
          stateNext = stFetch;
          rdNext    = 1'b1;
        end else begin
          opCodeNext  = irOp;
          operandNext = irOperand;
          cntNext     = CNT_LOAD;
          stateNext   = stIssue;
        end
      end
      stIssue: begin
        if (cntReg == '0) begin
          opCodeNext = OP_NOP;
`ifdef SEQ_SINGLE_STEP_EN
          stateNext  = stPause;
`else
          pcNext     = pcReg + ADDR_W'(1);
          stateNext  = stFetch;
          rdNext     = 1'b1;
`endif
        end else begin
          cntNext = cntReg - CNT_W'(1);
        end
      end
`ifdef SEQ_SINGLE_STEP_EN
      stPause: begin
        if (step) begin
          pcNext    = pcReg + ADDR_W'(1);
          stateNext = stFetch;
          rdNext    = 1'b1;
        end
      end
`endif
      default: stateNext = stIdle;
    endcase
  end

  always_comb begin
    busyNow = 1'b0;
    case (stateReg)
      stFetch, stWait, stDecode, stIssue: busyNow = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
      stPause: busyNow = 1'b1;
`endif
      default: busyNow = 1'b0;
    endcase
  end

  assign bus.instrAddr = pcReg;
  assign bus.instrRd   = rdReg;
  assign bus.opCode    = opCodeReg;
  assign bus.operand   = operandReg;
  assign bus.busy      = busyNow;
  assign bus.halted    = (stateReg == stHalted);
endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: table vectors, directed corner sequences and
// random programs compared against a program-level interpreter of the ROM contents.
module tb_instr_sequencer;
  localparam int IC = 2;
`ifdef SEQ_SINGLE_STEP_EN
  localparam int STEP_X = 1;
`else
  localparam int STEP_X = 0;
`endif
  localparam int P = 3 + IC + STEP_X;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start4 = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
  logic step = 1'b1;
`endif

  always #5 clk = ~clk;

  instr_sequencer_if #(.ADDR_W(8)) bus8 ();
  instr_sequencer_if #(.ADDR_W(4)) bus4 ();

  instr_sequencer #(.ADDR_W(8), .ISSUE_CYCLES(IC)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .bus(bus8)
  );

  instr_sequencer #(.ADDR_W(4), .ISSUE_CYCLES(IC)) dut4 (
    .clk(clk), .rst(rst), .start(start4),
`ifdef SEQ_SINGLE_STEP_EN
    .step(1'b1),
`endif
    .bus(bus4)
  );

  logic [11:0] rom8 [0:255];
  logic [7:0]  rom4 [0:15];
  always @(posedge clk) if (bus8.instrRd) bus8.instrData <= rom8[bus8.instrAddr];
  always @(posedge clk) if (bus4.instrRd) bus4.instrData <= rom4[bus4.instrAddr];

  int checks = 0;
  int errors = 0;

  // Monitor: per-cycle log plus fetch and issue-run records
  int cyc = 0;
  int fAddrQ[$], fCycQ[$];
  int iOpQ[$], iOperQ[$], iCycQ[$], iLenQ[$];
  logic [1:0] stLog[$];
  bit sawJmpOp = 0;
  int f4Q[$];

  always @(negedge clk) begin
    int last;
    if (bus8.instrRd) begin
      fAddrQ.push_back(int'(bus8.instrAddr));
      fCycQ.push_back(cyc);
    end
    if (bus8.opCode != 4'hF) begin
      last = iLenQ.size() - 1;
      if (last >= 0 && iCycQ[last] + iLenQ[last] == cyc &&
          iOpQ[last] == int'(bus8.opCode) && iOperQ[last] == int'(bus8.operand)) begin
        iLenQ[last] = iLenQ[last] + 1;
      end else begin
        iOpQ.push_back(int'(bus8.opCode));
        iOperQ.push_back(int'(bus8.operand));
        iCycQ.push_back(cyc);
        iLenQ.push_back(1);
      end
    end
    if (bus8.opCode == 4'hE) sawJmpOp = 1;
    stLog.push_back({bus8.busy, bus8.halted});
    if (bus4.instrRd) f4Q.push_back(int'(bus4.instrAddr));
    cyc++;
  end

  // Reference model results
  int mFAddr[$], mFCyc[$], mIOp[$], mIOper[$], mICyc[$];
  int mHalt;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic clearObs();
    fAddrQ.delete(); fCycQ.delete();
    iOpQ.delete(); iOperQ.delete(); iCycQ.delete(); iLenQ.delete();
    sawJmpOp = 0;
  endtask

  task automatic fillRom8(input logic [11:0] w);
    for (int a = 0; a < 256; a++) rom8[a] = w;
  endtask

  // Returns s = cycle index at which the first FETCH is observed
  task automatic startPulse(output int s);
    @(posedge clk); #1;
    start = 1'b1;
    s = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  // Interprets the program: what is fetched, what is issued, and when, inside [s, e)
  task automatic modelRun(input int s, input int e);
    int c, pc, w, op, opnd;
    mFAddr.delete(); mFCyc.delete(); mIOp.delete(); mIOper.delete(); mICyc.delete();
    mHalt = -1;
    c = s;
    pc = 0;
    while (c < e) begin
      mFAddr.push_back(pc);
      mFCyc.push_back(c);
      w = int'(rom8[pc]);
      op = (w >> 8) & 15;
      opnd = w & 255;
      if (op == 15) begin
        if (c + 3 < e) mHalt = c + 3;
        break;
      end else if (op == 14) begin
        pc = opnd;
        c += 3;
      end else begin
        if (c + 3 + IC <= e) begin
          mIOp.push_back(op); mIOper.push_back(opnd); mICyc.push_back(c + 3);
        end
        pc = (pc + 1) % 256;
        c += P;
      end
    end
  endtask

  task automatic compareRun(input string name, input int s, input int e);
    int oOp[$], oOper[$], oCyc[$], oLen[$];
    int n, oHalt, badBusy, busyEnd;
    for (int i = 0; i < iCycQ.size(); i++) begin
      if (iCycQ[i] + IC <= e) begin
        oOp.push_back(iOpQ[i]); oOper.push_back(iOperQ[i]);
        oCyc.push_back(iCycQ[i]); oLen.push_back(iLenQ[i]);
      end
    end
    chk({name, " fetch count"}, fAddrQ.size(), mFAddr.size());
    n = (fAddrQ.size() < mFAddr.size()) ? fAddrQ.size() : mFAddr.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s fetch%0d addr", name, i), fAddrQ[i], mFAddr[i]);
      chk($sformatf("%s fetch%0d cycle", name, i), fCycQ[i] - s, mFCyc[i] - s);
    end
    chk({name, " issue count"}, oOp.size(), mIOp.size());
    n = (oOp.size() < mIOp.size()) ? oOp.size() : mIOp.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s issue%0d opCode", name, i), oOp[i], mIOp[i]);
      chk($sformatf("%s issue%0d operand", name, i), oOper[i], mIOper[i]);
      chk($sformatf("%s issue%0d cycle", name, i), oCyc[i] - s, mICyc[i] - s);
      chk($sformatf("%s issue%0d hold", name, i), oLen[i], IC);
    end
    oHalt = -1;
    for (int c = s; c < e; c++) if (stLog[c][0] && oHalt < 0) oHalt = c;
    chk({name, " halt cycle"}, (oHalt < 0) ? -1 : oHalt - s, (mHalt < 0) ? -1 : mHalt - s);
    busyEnd = (mHalt >= 0) ? mHalt : e;
    badBusy = 0;
    for (int c = s; c < busyEnd; c++) if (!stLog[c][1]) badBusy++;
    if (mHalt >= 0 && stLog[mHalt][1]) badBusy++;
    chk({name, " busy window errors"}, badBusy, 0);
    chk({name, " JMP seen on opCode"}, int'(sawJmpOp), 0);
    $display("run %s: fetches=%0d issues=%0d halt=%0d", name, fAddrQ.size(), oOp.size(),
             (oHalt < 0) ? -1 : oHalt - s);
  endtask

  task automatic runProgram(input string name, input int len, input int extraAt, output int s);
    clearObs();
    startPulse(s);
    if (extraAt > 0) begin
      waitUntil(s + extraAt);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    waitUntil(s + len);
    modelRun(s, s + len);
    compareRun(name, s, s + len);
  endtask

  typedef struct {
    logic [11:0] word;
    int expOp;       // 15 when nothing is issued
    int expOperand;
    int expNFetch;   // fetches within a 20-cycle window
    int expSecond;   // second fetch address, -1 if none
    int expHalted;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int s, found, r, bad;
    int exp4[7];
    vecs[0] = '{12'h205, 2, 8'h05, 2, 1, 1};
    vecs[1] = '{12'hDFF, 13, 8'hFF, 2, 1, 1};
    vecs[2] = '{12'h000, 0, 0, 2, 1, 1};
    vecs[3] = '{12'hE10, 15, 0, 2, 16, 1};
    vecs[4] = '{12'hE00, 15, 0, 7, 0, 0};
    vecs[5] = '{12'hF00, 15, 0, 1, -1, 1};
    exp4 = '{0, 1, 2, 3, 15, 0, 1};
    for (int a = 0; a < 16; a++) rom4[a] = 8'h50;
    rom4[3] = 8'hEF;
    fillRom8(12'hF00);

    // Reset and idle
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("idle opCode", int'(bus8.opCode), 15);
    chk("idle instrRd", int'(bus8.instrRd), 0);
    chk("idle busy", int'(bus8.busy), 0);
    chk("idle halted", int'(bus8.halted), 0);
    chk("idle instrAddr", int'(bus8.instrAddr), 0);
    $display("reset/idle checked");

    // Table vectors: single instruction at address 0, HALT elsewhere
    for (int v = 0; v < 6; v++) begin
      fillRom8(12'hF00);
      rom8[0] = vecs[v].word;
      clearObs();
      startPulse(s);
      waitUntil(s + 20);
      chk($sformatf("vec%0d fetch count", v), fAddrQ.size(), vecs[v].expNFetch);
      if (vecs[v].expSecond >= 0 && fAddrQ.size() > 1)
        chk($sformatf("vec%0d second addr", v), fAddrQ[1], vecs[v].expSecond);
      chk($sformatf("vec%0d issue count", v), iOpQ.size(), (vecs[v].expOp == 15) ? 0 : 1);
      if (vecs[v].expOp != 15 && iOpQ.size() > 0) begin
        chk($sformatf("vec%0d opCode", v), iOpQ[0], vecs[v].expOp);
        chk($sformatf("vec%0d operand", v), iOperQ[0], vecs[v].expOperand);
        chk($sformatf("vec%0d hold", v), iLenQ[0], IC);
      end
      chk($sformatf("vec%0d halted", v), int'(stLog[s + 19][0]), vecs[v].expHalted);
      $display("vector %0d word=%03h fetches=%0d issues=%0d", v, vecs[v].word, fAddrQ.size(), iOpQ.size());
      doReset();
    end

    // Four-instruction program, then restart from HALTED with a start pulse during ISSUE
    fillRom8(12'hF00);
    rom8[0] = 12'h205; rom8[1] = 12'h307; rom8[2] = 12'h000; rom8[3] = 12'hF00;
    runProgram("prog4", 30, 0, s);
    for (int i = 0; i < 4; i++) if (i < fAddrQ.size()) begin
      chk($sformatf("prog4 addr%0d", i), fAddrQ[i], i);
      chk($sformatf("prog4 fetch time%0d", i), fCycQ[i] - s, P * i);
    end
    if (iOpQ.size() == 3) begin
      chk("prog4 op0", iOpQ[0], 2); chk("prog4 op1", iOpQ[1], 3); chk("prog4 op2", iOpQ[2], 0);
      chk("prog4 operand1", iOperQ[1], 7);
      chk("prog4 spacing", iCycQ[1] - iCycQ[0], P);
    end else chk("prog4 issues", iOpQ.size(), 3);
    chk("prog4 halted", int'(stLog[s + 3 * P + 3][0]), 1);
    runProgram("prog4 restart", 30, 7, s);

    // JMP forward: JMP never reaches opCode, start during WAIT is ignored
    doReset();
    fillRom8(12'hF00);
    rom8[0] = 12'hE10; rom8[8'h10] = 12'h100; rom8[8'h11] = 12'hF00;
    runProgram("jmp", 24, 1, s);
    if (fAddrQ.size() >= 2) begin
      chk("jmp first addr", fAddrQ[0], 0);
      chk("jmp target addr", fAddrQ[1], 16);
      chk("jmp target time", fCycQ[1] - s, 3);
    end
    if (iOpQ.size() >= 1) chk("jmp issued op", iOpQ[0], 1);

    // Reset while issuing opcode 6
    doReset();
    fillRom8(12'hF00);
    rom8[0] = 12'h62A;
    startPulse(s);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (bus8.opCode == 4'h6) found = 1;
    end
    chk("reach issue of 6", found, 1);
    chk("operand during issue", int'(bus8.operand), 42);
    #2 rst = 1'b1;
    #1;
    chk("async rst opCode", int'(bus8.opCode), 15);
    chk("async rst operand", int'(bus8.operand), 0);
    chk("async rst busy", int'(bus8.busy), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post rst busy", int'(bus8.busy), 0);
    $display("reset during issue checked");

    // PC wrap on the 4-bit instance
    f4Q.delete();
    @(posedge clk); #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("wrap fetch count>=7", int'(f4Q.size() >= 7), 1);
    for (int i = 0; i < 7; i++) if (i < f4Q.size()) chk($sformatf("wrap addr%0d", i), f4Q[i], exp4[i]);
    $display("wrap run: fetches=%0d", f4Q.size());
    doReset();

`ifdef SEQ_SINGLE_STEP_EN
    // Single step: park in PAUSE until step
    step = 1'b0;
    fillRom8(12'hF00);
    rom8[0] = 12'h205; rom8[1] = 12'h307;
    clearObs();
    startPulse(s);
    waitUntil(s + 3 + IC + 20);
    chk("pause fetch count", fAddrQ.size(), 1);
    bad = 0;
    for (int c = s + 3 + IC; c < s + 3 + IC + 20; c++) if (!stLog[c][1]) bad++;
    chk("pause busy errors", bad, 0);
    step = 1'b1;
    @(posedge clk); #1 step = 1'b0;
    @(negedge clk);
    chk("step instrRd", int'(bus8.instrRd), 1);
    chk("step instrAddr", int'(bus8.instrAddr), 1);
    step = 1'b1;
    $display("single step checked");
    doReset();
`endif

    // Random programs
    for (int t = 0; t < 15; t++) begin
      for (int a = 0; a < 256; a++) begin
        r = $urandom_range(0, 99);
        if (r < 8) rom8[a] = 12'hF00;
        else if (r < 18) rom8[a] = {4'hE, 8'($urandom_range(0, 255))};
        else rom8[a] = {4'($urandom_range(0, 13)), 8'($urandom_range(0, 255))};
      end
      runProgram($sformatf("rand%0d", t), 250, 0, s);
      doReset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
